// File: rtl/hazard_forward_unit.sv
// Load-use stall detection and EX operand-forward selection for a 5-stage pipeline.
// Tracks the EX/MEM/WB producer records and registers forward selects with the EX advance.
module hazard_forward_unit #(
    parameter int REGW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_src1,
    input  logic [REGW-1:0] id_src2,
    input  logic            id_use1,
    input  logic            id_use2,
    input  logic [REGW-1:0] id_dst,
    input  logic            id_wb,
    input  logic            id_mem_read,
    output logic            stall,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic [7:0]      stall_count
);

    typedef struct packed {
        logic            valid;
        logic [REGW-1:0] dst;
        logic            wb;
        logic            mem_read;
    } stage_t;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    stage_t     ex_q, ex_d, mem_q, wb_q;
    logic       live1, live2;
    logic       ex_hit1, ex_hit2, mem_hit1, mem_hit2;
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [7:0] cnt_q, cnt_d;

    // Youngest producer wins; a load still in EX never forwards (it stalls instead).
    function automatic logic [1:0] fwd_sel(input logic live, input logic ex_hit,
                                           input logic ex_load, input logic mem_hit);
        if (live && ex_hit && !ex_load) begin
            return FWD_MEM;
        end else if (live && mem_hit) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    always_comb begin
        live1    = id_valid & id_use1;
        live2    = id_valid & id_use2;
        ex_hit1  = ex_q.valid  & ex_q.wb  & (ex_q.dst  == id_src1);
        ex_hit2  = ex_q.valid  & ex_q.wb  & (ex_q.dst  == id_src2);
        mem_hit1 = mem_q.valid & mem_q.wb & (mem_q.dst == id_src1);
        mem_hit2 = mem_q.valid & mem_q.wb & (mem_q.dst == id_src2);

        stall = ex_q.mem_read & ((live1 & ex_hit1) | (live2 & ex_hit2));

        ex_d    = '0;
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (!stall) begin
            if (id_valid) begin
                ex_d = '{valid: 1'b1, dst: id_dst, wb: id_wb, mem_read: id_mem_read};
            end
            fwd_a_d = fwd_sel(live1, ex_hit1, ex_q.mem_read, mem_hit1);
            fwd_b_d = fwd_sel(live2, ex_hit2, ex_q.mem_read, mem_hit2);
        end

        cnt_d = cnt_q;
        if (stall && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fwd_a       = fwd_a_q;
    assign fwd_b       = fwd_b_q;
    assign stall_count = cnt_q;

    // WB is retained for pipeline bookkeeping; it must always trail MEM by one cycle.
    wb_follows_mem: assert property (@(posedge clk) disable iff (rst)
        !$past(rst) |-> (wb_q == $past(mem_q)));

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: stimulus pushes model expectations,
// a monitor pops and compares stall / fwd_a / fwd_b / stall_count every cycle.
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [2:0] id_src1, id_src2, id_dst;
    logic       id_use1, id_use2, id_wb, id_mem_read;
    logic       stall;
    logic [1:0] fwd_a, fwd_b;
    logic [7:0] stall_count;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REGW(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_use1     (id_use1),
        .id_use2     (id_use2),
        .id_dst      (id_dst),
        .id_wb       (id_wb),
        .id_mem_read (id_mem_read),
        .stall       (stall),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall_count (stall_count)
    );

    typedef struct {
        bit       v;
        bit [2:0] dst;
        bit       wb;
        bit       mr;
    } rec_t;

    typedef struct {
        bit       chk_st;
        bit       st;
        bit [1:0] fa;
        bit [1:0] fb;
        int       cnt;
    } exp_t;

    // hist[0] = instruction that most recently entered EX, hist[1] = the one before it
    rec_t hist[$];
    exp_t sb[$];
    int   mdl_cnt   = 0;
    bit   mdl_known = 1'b0;
    int   n_vec     = 0;
    int   n_bad     = 0;

    function automatic rec_t mk(input bit v, input bit [2:0] d, input bit wb, input bit mr);
        rec_t r;
        r.v = v; r.dst = d; r.wb = wb; r.mr = mr;
        return r;
    endfunction

    function automatic bit produces(input rec_t p, input bit [2:0] r);
        return p.v && p.wb && (p.dst == r);
    endfunction

    // Distance to the youngest older producer of src: 1 cycle ahead -> 1, 2 cycles ahead -> 2.
    function automatic bit [1:0] fwd_for(input bit live, input bit [2:0] src);
        if (!live) return 2'd0;
        for (int age = 0; age < 2; age++) begin
            if (produces(hist[age], src)) return (age == 0) ? 2'd1 : 2'd2;
        end
        return 2'd0;
    endfunction

    task automatic issue(input bit v, input bit [2:0] s1, input bit u1, input bit [2:0] s2,
                         input bit u2, input bit [2:0] d, input bit wb, input bit mr,
                         input bit r, output bit st);
        exp_t e;
        bit   l1, l2;
        @(negedge clk);
        rst = r; id_valid = v; id_src1 = s1; id_use1 = u1; id_src2 = s2; id_use2 = u2;
        id_dst = d; id_wb = wb; id_mem_read = mr;
        #1;
        l1 = v && u1;
        l2 = v && u2;
        st = (l1 && produces(hist[0], s1) && hist[0].mr) ||
             (l2 && produces(hist[0], s2) && hist[0].mr);
        e.chk_st = mdl_known;
        e.st     = st;
        if (r) begin
            e.fa = 2'd0; e.fb = 2'd0; e.cnt = 0;
        end else begin
            e.fa  = st ? 2'd0 : fwd_for(l1, s1);
            e.fb  = st ? 2'd0 : fwd_for(l2, s2);
            e.cnt = (st && mdl_cnt < 255) ? mdl_cnt + 1 : mdl_cnt;
        end
        sb.push_back(e);
        mdl_cnt = e.cnt;
        if (r) begin
            hist[0]   = mk(0, 0, 0, 0);
            hist[1]   = mk(0, 0, 0, 0);
            mdl_known = 1'b1;
        end else begin
            hist.push_front((v && !st) ? mk(1, d, wb, mr) : mk(0, 0, 0, 0));
            void'(hist.pop_back());
        end
    endtask

    // Present an instruction until it leaves ID (a load-use hazard holds it at most once).
    task automatic instr(input bit v, input bit [2:0] s1, input bit u1, input bit [2:0] s2,
                         input bit u2, input bit [2:0] d, input bit wb, input bit mr);
        bit st;
        int tries = 0;
        do begin
            issue(v, s1, u1, s2, u2, d, wb, mr, 1'b0, st);
            tries++;
        end while (st && tries < 3);
    endtask

    task automatic nop();
        instr(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic flush();
        nop();
        nop();
    endtask

    task automatic do_reset();
        bit st;
        issue(0, 0, 0, 0, 0, 0, 0, 0, 1'b1, st);
    endtask

    // Directed check of the selects (and optionally the count) after the next edge.
    task automatic expect_after(input bit [1:0] fa, input bit [1:0] fb, input int cnt,
                                input string name);
        @(posedge clk);
        #2;
        n_vec++;
        if (fwd_a !== fa || fwd_b !== fb || (cnt >= 0 && int'(stall_count) != cnt)) begin
            n_bad++;
            $display("FAIL %s: fwd_a=%0d fwd_b=%0d count=%0d, expected fwd_a=%0d fwd_b=%0d count=%0d",
                     name, fwd_a, fwd_b, stall_count, fa, fb, cnt);
        end
    endtask

    initial begin : monitor
        exp_t e;
        bit   s;
        forever begin
            @(negedge clk);
            #2;
            s = stall;
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL sb_underflow: DUT cycle with no expectation queued");
            end else begin
                e = sb.pop_front();
                if (e.chk_st) begin
                    n_vec++;
                    if (s !== e.st) begin
                        n_bad++;
                        $display("FAIL stall: got %0b expected %0b at %0t", s, e.st, $time);
                    end
                end
                n_vec++;
                if (fwd_a !== e.fa) begin
                    n_bad++;
                    $display("FAIL fwd_a: got %0d expected %0d at %0t", fwd_a, e.fa, $time);
                end
                n_vec++;
                if (fwd_b !== e.fb) begin
                    n_bad++;
                    $display("FAIL fwd_b: got %0d expected %0d at %0t", fwd_b, e.fb, $time);
                end
                n_vec++;
                if (int'(stall_count) != e.cnt) begin
                    n_bad++;
                    $display("FAIL stall_count: got %0d expected %0d at %0t", stall_count, e.cnt, $time);
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit st;
        hist.push_back(mk(0, 0, 0, 0));
        hist.push_back(mk(0, 0, 0, 0));
        rst = 1'b1; id_valid = 1'b0; id_src1 = '0; id_src2 = '0; id_use1 = 1'b0;
        id_use2 = 1'b0; id_dst = '0; id_wb = 1'b0; id_mem_read = 1'b0;

        do_reset();
        do_reset();

        // back-to-back ALU dependency: EX forward, no stall
        instr(1, 0, 0, 0, 0, 1, 1, 0);
        instr(1, 1, 1, 3, 1, 2, 1, 0);
        expect_after(2'd1, 2'd0, -1, "alu_alu_ex_fwd");
        flush();

        // one instruction apart: WB-path forward
        instr(1, 0, 0, 0, 0, 1, 1, 0);
        nop();
        instr(1, 1, 1, 0, 0, 1, 1, 0);
        expect_after(2'd2, 2'd0, -1, "alu_nop_mem_fwd");
        flush();

        // two producers of r1: youngest wins
        instr(1, 0, 0, 0, 0, 1, 1, 0);
        instr(1, 2, 1, 0, 0, 1, 1, 0);
        instr(1, 1, 1, 1, 1, 6, 1, 0);
        expect_after(2'd1, 2'd1, -1, "youngest_producer");
        flush();

        // unused source on a matching index, then store producer with wb=0
        instr(1, 0, 0, 0, 0, 1, 1, 0);
        instr(1, 1, 0, 1, 0, 3, 1, 0);
        expect_after(2'd0, 2'd0, -1, "use_bit_clear");
        instr(1, 0, 1, 0, 0, 2, 0, 0);
        instr(1, 2, 1, 2, 1, 4, 1, 0);
        expect_after(2'd0, 2'd0, -1, "store_no_fwd");
        flush();

        // destination equal to own source with no older producer
        instr(1, 3, 1, 3, 1, 3, 1, 0);
        expect_after(2'd0, 2'd0, -1, "no_self_dep");
        flush();

        // load-use: one stall, then both operands from the WB path
        do_reset();
        instr(1, 0, 0, 0, 0, 4, 1, 1);
        instr(1, 4, 1, 4, 1, 5, 1, 0);
        expect_after(2'd2, 2'd2, 1, "load_use");
        flush();

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                issue($urandom_range(0, 1), 3'($urandom_range(0, 3)), 1'b1,
                      3'($urandom_range(0, 3)), 1'b1, 3'($urandom_range(0, 3)), 1'b1,
                      1'b0, 1'b1, st);
            end else begin
                bit wb;
                wb = ($urandom_range(0, 4) != 0);
                instr(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), wb,
                      wb && ($urandom_range(0, 2) == 0));
            end
        end
        flush();

        for (int i = 0; i < 300; i++) begin
            instr(1, 0, 0, 0, 0, 4, 1, 1);
            instr(1, 4, 1, 4, 1, 5, 1, 0);
        end
        expect_after(2'd2, 2'd2, 255, "count_saturates");
        flush();

        // reset while the load-use stall is pending
        instr(1, 0, 0, 0, 0, 4, 1, 1);
        issue(1, 4, 1, 4, 1, 5, 1, 0, 1'b1, st);
        issue(1, 4, 1, 4, 1, 5, 1, 0, 1'b0, st);
        expect_after(2'd0, 2'd0, 0, "rst_mid_stall");
        flush();

        @(posedge clk);
        #3;
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
